pc_gen_unit: RTL

- Fetch-address generator directly upstream of the instruction-fetch stage; owns the architectural PC register and presents one PC per cycle via a valid/ready handshake.
- Sequences reset boot, sequential +4 advance, branch/trap redirects, hazard stalls with redirect buffering, and halt on ebreak.
- Output PC feeds the fetch stage's memory-read address and the difftest PC hook.

---
 rtl/pc_gen_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-address generator sitting directly upstream of the
// instruction-fetch stage. It owns the architectural PC and offers one PC per
// cycle over a valid/ready handshake. It handles boot, sequential +4 advance,
// branch/trap redirects, stall-time redirect buffering and halt on ebreak.
//
// Optional feature macro: PCG_PERF_CNT_EN
//   defined   -> redirect and stall performance counters are implemented
//   undefined -> o_redirect_cnt / o_stall_cnt are tied to zero and have no flops
module pc_gen_unit #(
  parameter int                   CPU_WIDTH  = 64,
  parameter logic [CPU_WIDTH-1:0] RESET_VEC  = 64'h8000_0000,
  parameter int                   INST_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_stall,
  input  logic                 i_ifu_ready,
  input  logic                 i_br_redirect,
  input  logic [CPU_WIDTH-1:0] i_br_target,
  input  logic                 i_trap_redirect,
  input  logic [CPU_WIDTH-1:0] i_trap_target,
  input  logic                 i_halt,
  output logic [CPU_WIDTH-1:0] o_pc,
  output logic                 o_pc_valid,
  output logic                 o_kill,
  output logic                 o_misalign,
  output logic [CPU_WIDTH-1:0] o_bad_pc,
  output logic [63:0]          o_redirect_cnt,
  output logic [63:0]          o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CPU_WIDTH-1:0] r_pc;
  logic                 r_pend_valid;
  logic                 r_pend_trap;
  logic [CPU_WIDTH-1:0] r_pend_pc;
  logic                 r_misalign;
  logic [CPU_WIDTH-1:0] r_bad_pc;

  logic                 w_run;
  logic                 w_redirect;
  logic                 w_fire;
  logic                 w_apply;
  logic [CPU_WIDTH-1:0] w_apply_raw;
  logic                 w_apply_odd;
  logic                 w_capture_trap;
  logic                 w_capture_br;

  assign w_redirect = i_br_redirect || i_trap_redirect;

  // A redirect is applied on the first unstalled RUN cycle that has either a
  // fresh request or a buffered one; a fresh request beats the buffered one.
  assign w_apply     = w_run && !i_stall && (r_pend_valid || w_redirect);
  assign w_apply_raw = i_trap_redirect ? i_trap_target :
                       i_br_redirect   ? i_br_target   : r_pend_pc;
  assign w_apply_odd = (w_apply_raw[1:0] != 2'b00);

  // While stalled, a trap always takes the buffer; a branch only takes it if
  // no trap is already waiting there.
  assign w_capture_trap = w_run && i_stall && i_trap_redirect;
  assign w_capture_br   = w_run && i_stall && !i_trap_redirect && i_br_redirect &&
                          !(r_pend_valid && r_pend_trap);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_BOOT;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: BOOT lasts one cycle, HALT is left only through reset.
  // NOTE: the default assignment up front keeps every path assigned, so no
  // latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  if (w_fire && i_halt) w_state_nxt = ST_HALT;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Output decode: handshake, squash and fire qualification.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    o_pc_valid = w_run && !i_stall && !r_pend_valid;
    o_kill     = o_pc_valid && w_redirect;
    w_fire     = o_pc_valid && i_ifu_ready && !w_redirect;
  end

  // PC, redirect buffer and misalignment report.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_VEC;
      r_pend_valid <= 1'b0;
      r_pend_trap  <= 1'b0;
      r_pend_pc    <= '0;
      r_misalign   <= 1'b0;
      r_bad_pc     <= '0;
    end else begin
      r_misalign <= w_apply && w_apply_odd;
      if (w_apply && w_apply_odd) r_bad_pc <= w_apply_raw;

      if (w_apply) begin
        r_pc         <= {w_apply_raw[CPU_WIDTH-1:2], 2'b00};
        r_pend_valid <= 1'b0;
      end else if (w_fire && !i_halt) begin
        // Plain modular add: the top word-aligned address wraps to zero.
        r_pc <= r_pc + CPU_WIDTH'(INST_BYTES);
      end

      if (w_capture_trap || w_capture_br) begin
        r_pend_valid <= 1'b1;
        r_pend_trap  <= w_capture_trap;
        r_pend_pc    <= w_capture_trap ? i_trap_target : i_br_target;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_misalign = r_misalign;
  assign o_bad_pc   = r_bad_pc;

`ifdef PCG_PERF_CNT_EN
  logic [63:0] r_redirect_cnt;
  logic [63:0] r_stall_cnt;

  // Performance counters: applied redirects and stalled RUN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_apply)           r_redirect_cnt <= r_redirect_cnt + 64'd1;
      if (w_run && i_stall)  r_stall_cnt    <= r_stall_cnt + 64'd1;
    end
  end

  assign o_redirect_cnt = r_redirect_cnt;
  assign o_stall_cnt    = r_stall_cnt;
`else
  assign o_redirect_cnt = 64'd0;
  assign o_stall_cnt    = 64'd0;
`endif

endmodule
